// File: rtl/rx_acq_gate_pkg.sv
// Shared definitions for the RX acquisition path: FSM encoding, default widths, status flags.
// Used by the pulser, capture and acquisition-gate blocks.
package rx_acq_gate_pkg;

  localparam int DW_DEF = 14;
  localparam int CW_DEF = 8;

  typedef logic [2:0] acq_state_t;

  localparam acq_state_t ST_IDLE  = 3'd0;
  localparam acq_state_t ST_ARMED = 3'd1;
  localparam acq_state_t ST_PULSE = 3'd2;
  localparam acq_state_t ST_DEAD  = 3'd3;
  localparam acq_state_t ST_ACQ   = 3'd4;
  localparam acq_state_t ST_DONE  = 3'd5;

  typedef struct packed {
    logic overrun;
    logic aborted;
  } acq_flags_t;

  // States in which a new transmit pulse cuts the record short.
  function automatic logic is_window(input acq_state_t s);
    return (s == ST_DEAD) || (s == ST_ACQ);
  endfunction

endpackage

// File: rtl/rx_acq_gate_edge.sv
// Registered edge detector for the transmitter unblank gate.
// Latency: rise/fall valid in the cycle the input changes. Backpressure: none.
module rx_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = sig_q & ~sig;

endmodule

// File: rtl/rx_acq_gate.sv
// Receive acquisition gate: opens the ADC window dead_time clks after the TX pulse falls.
// Latency: sample_data is adc_data delayed one clk; window length is the record_len latched at the fall.
// Backpressure: none; a sample offered with sample_ready low is dropped and sets sticky overrun.
module rx_acq_gate
  import rx_acq_gate_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          u_blank,
  input  logic [CW-1:0] dead_time,
  input  logic [CW-1:0] record_len,
  input  logic [DW-1:0] adc_data,
  input  logic          sample_ready,
  output logic          rx_gate,
  output logic [DW-1:0] sample_data,
  output logic          sample_valid,
  output logic [CW-1:0] sample_idx,
  output logic          sample_last,
  output logic          rec_done,
  output logic          overrun,
  output logic          aborted
);

  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic          ub_rise;
  logic          ub_fall;
  acq_state_t    state;
  acq_state_t    state_nxt;
  logic [CW-1:0] dead_cnt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] idx_q;
  logic [DW-1:0] data_q;
  acq_flags_t    flags;
  logic          idx_at_end;
  logic          arm_evt;
  logic          abort_evt;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  rx_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_int_n),
    .sig   (u_blank),
    .rise  (ub_rise),
    .fall  (ub_fall)
  );

  // u_blank is always low on entry to DEAD/ACQ, so its first high level there is a rise.
  assign abort_evt  = is_window(state) && ub_rise;
  assign arm_evt    = (state == ST_IDLE) && enable;
  assign idx_at_end = (idx_q == len_q - CW'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)      state_nxt = ST_IDLE;
        else if (u_blank) state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        if (ub_fall) begin
          if (dead_time != '0)       state_nxt = ST_DEAD;
          else if (record_len != '0) state_nxt = ST_ACQ;
          else                       state_nxt = ST_DONE;
        end
      end
      ST_DEAD: begin
        if (abort_evt)                   state_nxt = ST_PULSE;
        else if (dead_cnt == CW'(1))     state_nxt = (len_q != '0) ? ST_ACQ : ST_DONE;
      end
      ST_ACQ: begin
        if (abort_evt)       state_nxt = ST_PULSE;
        else if (idx_at_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = enable ? ST_ARMED : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      flags    <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= adc_data;

      // Record parameters are frozen at the pulse fall edge.
      if ((state == ST_PULSE) && ub_fall) begin
        dead_cnt <= dead_time;
        len_q    <= record_len;
      end else if (state == ST_DEAD) begin
        dead_cnt <= dead_cnt - CW'(1);
      end

      if (state_nxt == ST_ACQ) begin
        idx_q <= (state == ST_ACQ) ? idx_q + CW'(1) : '0;
      end else begin
        idx_q <= '0;
      end

      if (arm_evt) begin
        flags <= '0;
      end else begin
        if (sample_valid && !sample_ready) flags.overrun <= 1'b1;
        if (abort_evt)                     flags.aborted <= 1'b1;
      end
    end
  end

  assign rx_gate      = (state == ST_ACQ);
  assign sample_valid = (state == ST_ACQ);
  assign sample_data  = data_q;
  assign sample_idx   = idx_q;
  assign sample_last  = (state == ST_ACQ) && idx_at_end;
  assign rec_done     = (state == ST_DONE);
  assign overrun      = flags.overrun;
  assign aborted      = flags.aborted;

endmodule

// File: doc/rx_acq_gate.md
RX_ACQ_GATE -- requirements
Module: rx_acq_gate

Interface
REQ-001 Parameter DW, default 14, ADC sample width.
REQ-002 Parameter CW, default 8, width of dead_time, record_len and sample_idx.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 enable  in  1  arms the block; low returns it to IDLE at the next record boundary.
REQ-006 u_blank  in  1  transmitter unblank gate from the pulser, clk-synchronous; high = RF pulse active.
REQ-007 dead_time  in  CW  cycles to wait after u_blank falls before acquiring.
REQ-008 record_len  in  CW  samples per record.
REQ-009 adc_data  in  DW  ADC sample, new value every clk.
REQ-010 sample_ready  in  1  downstream accepts a sample this cycle.
REQ-011 rx_gate  out  1  receiver window open.
REQ-012 sample_data  out  DW  captured sample.
REQ-013 sample_valid  out  1  sample_data valid.
REQ-014 sample_idx  out  CW  index of the current sample in the record, starting at 0.
REQ-015 sample_last  out  1  high with the final sample of the record.
REQ-016 rec_done  out  1  one-cycle pulse when a record completes.
REQ-017 overrun  out  1  sticky: a valid sample was dropped.
REQ-018 aborted  out  1  sticky: a record was cut short by a new pulse.

Function
REQ-019 The FSM SHALL have states IDLE, ARMED, PULSE, DEAD, ACQ, DONE.
REQ-020 IDLE->ARMED when enable=1; ARMED->PULSE when u_blank=1; ARMED->IDLE when enable=0.
REQ-021 The block SHALL register u_blank into ub_q. The fall edge E0 is the clk edge where ub_q=1 and u_blank=0 while in PULSE.
REQ-022 At E0 the block SHALL latch dead_time and record_len. Input changes after E0 SHALL NOT affect the current record.
REQ-023 At E0 the state SHALL become DEAD with counter=dead_time; if dead_time=0 it SHALL go directly to ACQ.
REQ-024 DEAD SHALL decrement the counter once per cycle and enter ACQ at edge E0+dead_time.
REQ-025 In ACQ, rx_gate and sample_valid SHALL be high for exactly the latched record_len consecutive cycles.
REQ-026 sample_data SHALL equal adc_data delayed by one clk.
REQ-027 sample_idx SHALL count 0..record_len-1. sample_last SHALL be high only at idx record_len-1.
REQ-028 If record_len=0 at E0, the block SHALL skip ACQ (no samples) and go DEAD->DONE or E0->DONE.
REQ-029 DONE SHALL last one cycle with rec_done=1, then go to ARMED if enable=1, otherwise IDLE.
REQ-030 enable=0 during DEAD or ACQ SHALL NOT truncate the record.
REQ-031 u_blank=1 during DEAD or ACQ SHALL end the record immediately: rx_gate and sample_valid drop next cycle, aborted=1, no rec_done, state=PULSE.
REQ-032 sample_valid=1 with sample_ready=0 SHALL set overrun. The sample is dropped and the window is not stalled.
REQ-033 overrun and aborted SHALL clear only on reset or on the IDLE->ARMED transition.
REQ-034 Counters SHALL be CW bits unsigned, with no wrap: the maximum record is 2^CW-1 samples.

Reset
REQ-035 While rst_n=0, the state SHALL be IDLE, ub_q=0, and every output and counter SHALL be 0, asynchronously.
REQ-036 rst_n rising mid-record SHALL restart from IDLE and require a new enable and a new pulse.
REQ-037 Reset deassertion SHALL be synchronised to clk inside the block.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding and the DW/CW defaults, which are also used by the pulser and capture blocks.
REQ-039 A single sub-module rx_edge_det (registered fall/rise detector on u_blank) SHALL be used. All other logic SHALL be flat.

Verification
REQ-040 enable=1, dead_time=3, record_len=5, ramp adc_data, u_blank high for 10 cycles -> rx_gate high edges E0+3..E0+7, idx 0..4, last at idx 4, rec_done at E0+8, data = ramp delayed by 1.
REQ-041 dead_time=0, record_len=1 -> a single sample at E0 with sample_last=1, rec_done the next cycle.
REQ-042 record_len=0 -> no sample_valid, rec_done pulses, state returns to ARMED.
REQ-043 u_blank re-asserted at sample idx 2 of record_len=8 -> valid drops next cycle, aborted=1, no rec_done; the next pulse yields a full record.
REQ-044 sample_ready=0 for one ACQ cycle -> overrun=1, the sample count is still record_len; the flag clears on IDLE->ARMED.
REQ-045 rst_n low at sample idx 3 -> all outputs 0 immediately; no activity until enable and a new u_blank pulse.
